// File: rtl/regfile_seq_ctrl.sv
// Stage sequencer (IF/ID/EX/MEM/WB) and regfile write-port arbiter.
// While halted, the write port is lent to the debug/loader interface.
module regfile_seq_ctrl #(
    parameter int XLEN      = 64,
    parameter int CNT_W     = 32,
    parameter int MAX_WAIT  = 15,
    parameter int RESET_RUN = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             halt_req,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    input  logic             is_mem,
    input  logic             core_we,
    input  logic [4:0]       core_rd,
    input  logic [XLEN-1:0]  core_wval,
    input  logic             dbg_req,
    input  logic [4:0]       dbg_rd,
    input  logic [XLEN-1:0]  dbg_wval,
    output logic             dbg_ack,
    output logic [2:0]       counter,
    output logic             rf_we,
    output logic [4:0]       rf_rd,
    output logic [XLEN-1:0]  rf_wval,
    output logic             halted,
    output logic             err,
    output logic [CNT_W-1:0] instr_cnt
);

    localparam logic [2:0] S_IF   = 3'd0;
    localparam logic [2:0] S_ID   = 3'd1;
    localparam logic [2:0] S_EX   = 3'd2;
    localparam logic [2:0] S_MEM  = 3'd3;
    localparam logic [2:0] S_WB   = 3'd4;
    localparam logic [2:0] S_HALT = 3'd5;

    localparam int               WAIT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MAX_WAIT);
    localparam logic [2:0]       S_RESET  = (RESET_RUN != 0) ? S_IF : S_HALT;
    localparam logic             HALTED_RESET = (RESET_RUN != 0) ? 1'b0 : 1'b1;

    logic [2:0]        state_r;
    logic [2:0]        state_nxt;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic [WAIT_W-1:0] wait_cnt_nxt;
    logic              err_r;
    logic              err_nxt;
    logic              is_mem_r;
    logic              is_mem_nxt;
    logic              halt_pend_r;
    logic              halt_pend_nxt;
    logic              halted_r;
    logic [CNT_W-1:0]  instr_cnt_r;
    logic [CNT_W-1:0]  instr_cnt_nxt;
    logic              dbg_grant;

    assign dbg_grant = (state_r == S_HALT) & dbg_req;

    // Next-state, stall/timeout and retirement bookkeeping
    always_comb begin
        state_nxt     = state_r;
        wait_cnt_nxt  = wait_cnt_r;
        err_nxt       = err_r;
        is_mem_nxt    = is_mem_r;
        instr_cnt_nxt = instr_cnt_r;
        case (state_r)
            S_HALT: begin
                if (dbg_req) begin
                    state_nxt = S_HALT;
                end else if (halt_req) begin
                    state_nxt = S_HALT;
                end else if (run) begin
                    state_nxt    = S_IF;
                    err_nxt      = 1'b0;
                    wait_cnt_nxt = {WAIT_W{1'b0}};
                end else begin
                    state_nxt = S_HALT;
                end
            end
            S_IF: begin
                if (imem_ready) begin
                    state_nxt    = S_ID;
                    wait_cnt_nxt = {WAIT_W{1'b0}};
                end else if (wait_cnt_r == WAIT_LIM) begin
                    state_nxt    = S_HALT;
                    err_nxt      = 1'b1;
                    wait_cnt_nxt = {WAIT_W{1'b0}};
                end else begin
                    wait_cnt_nxt = wait_cnt_r + WAIT_W'(1);
                end
            end
            S_ID: begin
                is_mem_nxt = is_mem;
                state_nxt  = S_EX;
            end
            S_EX: begin
                state_nxt = S_MEM;
            end
            S_MEM: begin
                if (!is_mem_r) begin
                    state_nxt = S_WB;
                end else if (dmem_ready) begin
                    state_nxt    = S_WB;
                    wait_cnt_nxt = {WAIT_W{1'b0}};
                end else if (wait_cnt_r == WAIT_LIM) begin
                    state_nxt    = S_HALT;
                    err_nxt      = 1'b1;
                    wait_cnt_nxt = {WAIT_W{1'b0}};
                end else begin
                    wait_cnt_nxt = wait_cnt_r + WAIT_W'(1);
                end
            end
            S_WB: begin
                instr_cnt_nxt = instr_cnt_r + CNT_W'(1);
                if (halt_req | halt_pend_r) begin
                    state_nxt = S_HALT;
                end else begin
                    state_nxt = S_IF;
                end
            end
            default: begin
                state_nxt    = S_HALT;
                wait_cnt_nxt = {WAIT_W{1'b0}};
            end
        endcase
    end

    // A halt request seen mid-instruction is remembered until the instruction retires
    always_comb begin
        if (state_nxt == S_HALT) begin
            halt_pend_nxt = 1'b0;
        end else begin
            halt_pend_nxt = halt_pend_r | halt_req;
        end
    end

    // Sequencer state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= S_RESET;
            wait_cnt_r  <= {WAIT_W{1'b0}};
            err_r       <= 1'b0;
            is_mem_r    <= 1'b0;
            halt_pend_r <= 1'b0;
            halted_r    <= HALTED_RESET;
            instr_cnt_r <= {CNT_W{1'b0}};
        end else begin
            state_r     <= state_nxt;
            wait_cnt_r  <= wait_cnt_nxt;
            err_r       <= err_nxt;
            is_mem_r    <= is_mem_nxt;
            halt_pend_r <= halt_pend_nxt;
            halted_r    <= (state_nxt == S_HALT);
            instr_cnt_r <= instr_cnt_nxt;
        end
    end

    // Write-port mux: debug only while halted, core only in WB
    always_comb begin
        if (dbg_grant) begin
            dbg_ack = 1'b1;
            rf_we   = (dbg_rd != 5'd0);
            rf_rd   = dbg_rd;
            rf_wval = dbg_wval;
        end else if (state_r == S_WB) begin
            dbg_ack = 1'b0;
            rf_we   = core_we & (core_rd != 5'd0);
            rf_rd   = core_rd;
            rf_wval = core_wval;
        end else begin
            dbg_ack = 1'b0;
            rf_we   = 1'b0;
            rf_rd   = 5'd0;
            rf_wval = {XLEN{1'b0}};
        end
    end

    // A debug grant presents itself to the regfile as a WB-stage write
    assign counter   = dbg_grant ? 3'd4 : state_r;
    assign halted    = halted_r;
    assign err       = err_r;
    assign instr_cnt = instr_cnt_r;

endmodule

// File: tb/tb_regfile_seq_ctrl.sv
// Randomized bench for regfile_seq_ctrl against a per-cycle behavioural model
// of the pipeline-stage sequencer and write-port sharing.
module tb_regfile_seq_ctrl;

    localparam int XLEN     = 64;
    localparam int CNT_W    = 32;
    localparam int MAX_WAIT = 15;

    logic             clk = 1'b0;
    logic             rst;
    logic             run, halt_req, imem_ready, dmem_ready, is_mem, core_we;
    logic [4:0]       core_rd;
    logic [XLEN-1:0]  core_wval;
    logic             dbg_req;
    logic [4:0]       dbg_rd;
    logic [XLEN-1:0]  dbg_wval;
    logic             dbg_ack;
    logic [2:0]       counter;
    logic             rf_we;
    logic [4:0]       rf_rd;
    logic [XLEN-1:0]  rf_wval;
    logic             halted, err;
    logic [CNT_W-1:0] instr_cnt;

    regfile_seq_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT), .RESET_RUN(0)) dut (
        .clk(clk), .rst(rst), .run(run), .halt_req(halt_req),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .is_mem(is_mem),
        .core_we(core_we), .core_rd(core_rd), .core_wval(core_wval),
        .dbg_req(dbg_req), .dbg_rd(dbg_rd), .dbg_wval(dbg_wval), .dbg_ack(dbg_ack),
        .counter(counter), .rf_we(rf_we), .rf_rd(rf_rd), .rf_wval(rf_wval),
        .halted(halted), .err(err), .instr_cnt(instr_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: halted flag, current stage 0..4, consecutive not-ready count
    bit               m_halted;
    int               m_stage;
    int               m_stall;
    bit               m_err;
    bit               m_mem;
    bit               m_pend;
    logic [CNT_W-1:0] m_cnt;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_halted = 1'b1; m_stage = 0; m_stall = 0; m_err = 1'b0;
        m_mem = 1'b0; m_pend = 1'b0; m_cnt = '0;
    endtask

    task automatic compare_outputs();
        logic [2:0]      e_counter;
        logic            e_ack, e_we;
        logic [4:0]      e_rd;
        logic [XLEN-1:0] e_wval;
        e_ack = m_halted && dbg_req;
        e_counter = m_halted ? (dbg_req ? 3'd4 : 3'd5) : 3'(m_stage);
        e_we = 1'b0; e_rd = 5'd0; e_wval = '0;
        if (e_ack) begin
            e_we = (dbg_rd != 5'd0); e_rd = dbg_rd; e_wval = dbg_wval;
        end else if (!m_halted && m_stage == 4) begin
            e_we = core_we && (core_rd != 5'd0); e_rd = core_rd; e_wval = core_wval;
        end
        check_eq("counter", counter, e_counter);
        check_eq("dbg_ack", dbg_ack, e_ack);
        check_eq("rf_we", rf_we, e_we);
        check_eq("rf_rd", rf_rd, e_rd);
        check_eq("rf_wval", rf_wval, e_wval);
        check_eq("halted", halted, m_halted);
        check_eq("err", err, m_err);
        check_eq("instr_cnt", instr_cnt, m_cnt);
    endtask

    // Wait-or-advance rule shared by fetch and data access
    task automatic model_wait(input bit ready, input int next_stage);
        if (ready) begin
            m_stage = next_stage; m_stall = 0;
        end else if (m_stall == MAX_WAIT) begin
            m_halted = 1'b1; m_err = 1'b1; m_stall = 0; m_pend = 1'b0;
        end else begin
            m_stall++;
        end
    endtask

    task automatic model_step();
        if (m_halted) begin
            if (!dbg_req && !halt_req && run) begin
                m_halted = 1'b0; m_stage = 0; m_stall = 0; m_err = 1'b0;
            end
        end else begin
            if (halt_req) m_pend = 1'b1;
            case (m_stage)
                0: model_wait(imem_ready, 1);
                1: begin m_mem = is_mem; m_stage = 2; end
                2: m_stage = 3;
                3: if (!m_mem) m_stage = 4; else model_wait(dmem_ready, 4);
                default: begin
                    m_cnt = m_cnt + 1'b1;
                    if (m_pend) begin m_halted = 1'b1; m_pend = 1'b0; end
                    else m_stage = 0;
                end
            endcase
        end
    endtask

    // Called just after a falling edge with inputs already set
    task automatic cycle();
        #1;
        compare_outputs();
        model_step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        run = 0; halt_req = 0; imem_ready = 1; dmem_ready = 1; is_mem = 0;
        core_we = 0; core_rd = 5'd0; core_wval = '0;
        dbg_req = 0; dbg_rd = 5'd0; dbg_wval = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        #1 compare_outputs();
        @(negedge clk);
        rst = 1'b0;

        // 1: single instruction, no stalls
        run = 1; core_we = 1; core_rd = 5'd5; core_wval = 64'h0123_4567_89AB_CDEF;
        cycle();
        run = 0;
        for (int i = 0; i < 5; i++) cycle();
        check_eq("t1_instr_cnt", instr_cnt, 64'd1);

        // 2: 3 fetch stalls plus 2 data stalls -> 10 cycles
        is_mem = 1;
        for (int i = 0; i < 10; i++) begin
            imem_ready = !(m_stage == 0 && m_stall < 3);
            dmem_ready = !(m_stage == 3 && m_stall < 2);
            cycle();
        end
        check_eq("t2_instr_cnt", instr_cnt, 64'd2);
        check_eq("t2_counter", counter, 64'd0);

        // 3: fetch timeout
        imem_ready = 0; is_mem = 0;
        for (int i = 0; i < 16; i++) cycle();
        check_eq("t3_halted", halted, 64'd1);
        check_eq("t3_err", err, 64'd1);
        run = 1; imem_ready = 1;
        cycle();
        run = 0;
        check_eq("t3_err_clr", err, 64'd0);
        check_eq("t3_resume", counter, 64'd0);

        // 4: halt_req pulsed in EX
        for (int i = 0; i < 10 && !(m_stage == 2 && !m_halted); i++) cycle();
        check_eq("t4_in_ex", counter, 64'd2);
        halt_req = 1;
        cycle();
        halt_req = 0;
        cycle();
        cycle();
        check_eq("t4_halted", halted, 64'd1);
        check_eq("t4_counter", counter, 64'd5);
        check_eq("t4_instr_cnt", instr_cnt, 64'd3);
        run = 1; halt_req = 1;
        for (int i = 0; i < 3; i++) cycle();
        check_eq("t4_halt_beats_run", halted, 64'd1);

        // 5: debug writes while halted, then while running
        run = 0; halt_req = 0;
        dbg_req = 1; dbg_rd = 5'd7; dbg_wval = 64'h0000_0000_DEAD_BEEF;
        #1;
        check_eq("t5_ack", dbg_ack, 64'd1);
        check_eq("t5_counter", counter, 64'd4);
        check_eq("t5_we", rf_we, 64'd1);
        cycle();
        dbg_rd = 5'd0;
        #1;
        check_eq("t5_ack_rd0", dbg_ack, 64'd1);
        check_eq("t5_we_rd0", rf_we, 64'd0);
        cycle();
        dbg_req = 0; run = 1;
        cycle();
        run = 0; dbg_req = 1; dbg_rd = 5'd9;
        for (int i = 0; i < 3; i++) cycle();
        halt_req = 1;
        for (int i = 0; i < 20 && !m_halted; i++) cycle();
        halt_req = 0;
        #1;
        check_eq("t5_ack_at_halt", dbg_ack, 64'd1);
        cycle();
        dbg_req = 0;

        // 6: asynchronous reset while stalled in MEM with a pending write
        run = 1; is_mem = 1; dmem_ready = 0; core_we = 1; core_rd = 5'd5;
        for (int i = 0; i < 20 && !(m_stage == 3 && !m_halted); i++) begin
            cycle();
            run = 0;
        end
        check_eq("t6_in_mem", counter, 64'd3);
        #2 rst = 1'b1;
        #1;
        check_eq("t6_counter", counter, 64'd5);
        check_eq("t6_we", rf_we, 64'd0);
        check_eq("t6_instr_cnt", instr_cnt, 64'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // Randomized traffic with varying memory readiness
        for (int i = 0; i < 4000; i++) begin
            int rdy_pct;
            rdy_pct    = (i < 2000) ? 70 : 12;
            run        = ($urandom_range(99) < 50);
            halt_req   = ($urandom_range(99) < 8);
            imem_ready = ($urandom_range(99) < rdy_pct);
            dmem_ready = ($urandom_range(99) < rdy_pct);
            is_mem     = $urandom_range(1);
            core_we    = $urandom_range(1);
            core_rd    = ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom);
            core_wval  = {$urandom, $urandom};
            dbg_req    = ($urandom_range(99) < 30);
            dbg_rd     = ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom);
            dbg_wval   = {$urandom, $urandom};
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
